// File: rtl/alu_lockstep_monitor.sv
// -----------------------------------------------------------------------------
// alu_lockstep_monitor
//
// Watches the two lockstep 4-bit ALU copies. On every accepted strobe it
// compares results and carries. Each disagreement is counted and logged as a
// record {sample idx, out1, out2, c1, c2} in a small show-ahead FIFO. A
// valid/ready reader drains that FIFO. Capture freezes once a configurable
// number of mismatches has been seen.
//
// Optional feature macro: ALU_MON_IRQ_EN
//   defined   -> irq_o is a registered level = rd_valid_o | ovf_o | halted_o
//   undefined -> irq_o is tied low and no interrupt logic exists
//
// Ports
//   wb_clk_i      in   clock, all state on rising edge
//   wb_rst_ni     in   asynchronous active-low reset
//   enable_i      in   capture enable (IDLE <-> RUN)
//   clear_i       in   synchronous clear of counters, FIFO, flags and FSM
//   valid_i       in   sample strobe for the current ALU outputs
//   alu_out1_i    in   result of ALU copy 1
//   alu_out2_i    in   result of ALU copy 2
//   carry1_i      in   carry of ALU copy 1
//   carry2_i      in   carry of ALU copy 2
//   rd_valid_o    out  FIFO head valid (FIFO not empty)
//   rd_ready_i    in   reader accepts the head entry
//   rd_data_o     out  head record {idx, out1, out2, c1, c2}
//   sample_cnt_o  out  accepted samples, saturating
//   mism_cnt_o    out  mismatching samples, saturating
//   ovf_o         out  sticky: a record was dropped because the FIFO was full
//   halted_o      out  FSM is in HALT
//   irq_o         out  interrupt level (see macro above)
// -----------------------------------------------------------------------------
module alu_lockstep_monitor #(
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16,
    parameter int IDX_W       = 8,
    parameter int HALT_THRESH = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic               valid_i,
    input  logic [3:0]         alu_out1_i,
    input  logic [3:0]         alu_out2_i,
    input  logic               carry1_i,
    input  logic               carry2_i,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [IDX_W+9:0]   rd_data_o,
    output logic [CNT_W-1:0]   sample_cnt_o,
    output logic [CNT_W-1:0]   mism_cnt_o,
    output logic               ovf_o,
    output logic               halted_o,
    output logic               irq_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int REC_W = IDX_W + 10;

    localparam logic [PTR_W:0] DEPTH_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT    = (PTR_W+1)'(1);
    localparam logic [CNT_W-1:0] HALT_VAL = CNT_W'(HALT_THRESH);
    localparam bit HALT_EN                = (HALT_THRESH != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   sample_cnt_reg, sample_cnt_next;
    logic [CNT_W-1:0]   mism_cnt_reg, mism_cnt_next;
    logic [PTR_W:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]     rd_ptr_reg, rd_ptr_next;
    logic               ovf_reg, ovf_next;
    logic [REC_W-1:0]   head_reg, head_next;

    logic [REC_W-1:0]   mem [DEPTH];

    logic [3:0]         bit_diff;
    logic               mismatch;
    logic               accept;
    logic               push_req;
    logic               push_do;
    logic               pop;
    logic [PTR_W:0]     occupancy;
    logic               empty;
    logic               full;
    logic               head_is_new;
    logic [CNT_W-1:0]   mism_cnt_inc;
    logic [REC_W-1:0]   push_record;

    // Bitwise disagreement between the two result buses.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_diff
            assign bit_diff[gi] = alu_out1_i[gi] ^ alu_out2_i[gi];
        end
    endgenerate

    assign mismatch = (|bit_diff) | (carry1_i ^ carry2_i);

    // A strobe only counts while running and still enabled in the same cycle,
    // so a sample arriving together with enable_i falling is dropped.
    assign accept   = valid_i & enable_i & (state_reg == ST_RUN);
    assign push_req = accept & mismatch;

    assign occupancy = wr_ptr_reg - rd_ptr_reg;
    assign empty     = (occupancy == '0);
    assign full      = (occupancy == DEPTH_CNT);
    assign pop       = ~empty & rd_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_do   = push_req & (~full | pop);

    // The pushed record becomes the head when nothing else remains after pop.
    assign head_is_new = push_do & (empty | (pop & (occupancy == ONE_CNT)));

    assign mism_cnt_inc = (mism_cnt_reg == '1) ? mism_cnt_reg : mism_cnt_reg + 1'b1;
    assign push_record  = {sample_cnt_reg[IDX_W-1:0], alu_out1_i, alu_out2_i,
                           carry1_i, carry2_i};

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        mism_cnt_next   = mism_cnt_reg;
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        ovf_next        = ovf_reg;
        head_next       = head_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (HALT_EN && push_req && (mism_cnt_inc == HALT_VAL)) begin
                    state_next = ST_HALT;
                end else if (!enable_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (accept && (sample_cnt_reg != '1)) begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
        end
        if (push_req) begin
            mism_cnt_next = mism_cnt_inc;
        end
        if (push_do) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push_req && full && !pop) begin
            ovf_next = 1'b1;
        end

        // Show-ahead head register: zero when the FIFO ends up empty.
        if (wr_ptr_next == rd_ptr_next) begin
            head_next = '0;
        end else if (head_is_new) begin
            head_next = push_record;
        end else begin
            head_next = mem[rd_ptr_next[PTR_W-1:0]];
        end

        if (clear_i) begin
            state_next      = ST_IDLE;
            sample_cnt_next = '0;
            mism_cnt_next   = '0;
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            ovf_next        = 1'b0;
            head_next       = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg      <= ST_IDLE;
            sample_cnt_reg <= '0;
            mism_cnt_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            ovf_reg        <= 1'b0;
            head_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            mism_cnt_reg   <= mism_cnt_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            ovf_reg        <= ovf_next;
            head_reg       <= head_next;
        end
    end

    // Record storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge wb_clk_i) begin
        if (push_do && !clear_i) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_record;
        end
    end

    assign rd_valid_o   = ~empty;
    assign rd_data_o    = head_reg;
    assign sample_cnt_o = sample_cnt_reg;
    assign mism_cnt_o   = mism_cnt_reg;
    assign ovf_o        = ovf_reg;
    assign halted_o     = (state_reg == ST_HALT);

`ifdef ALU_MON_IRQ_EN
    logic irq_reg;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_reg <= 1'b0;
        end else if (clear_i) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= rd_valid_o | ovf_reg | halted_o;
        end
    end

    assign irq_o = irq_reg;
`else
    assign irq_o = 1'b0;
`endif

endmodule
